// File: rtl/clock_pkg.sv
// Shared clock-core types: alarm sequencer states, speaker-select codes and time limits.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    DONE   = 2'd3
  } alarm_state_t;

  localparam logic [1:0] SPK_OFF   = 2'b00;
  localparam logic [1:0] SPK_CHIME = 2'b01;
  localparam logic [1:0] SPK_ALARM = 2'b10;

  localparam logic [5:0] MAX_HOUR = 6'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;

endpackage

// File: rtl/second_tick.sv
// Registers the seconds value and flags a tick on any cycle where it differs from last cycle.
// Reset loads the live value so the first cycle out of reset never ticks.
module second_tick (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] second,
  output logic       tick
);

  logic [5:0] second_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      second_q <= second;
    end else begin
      second_q <= second;
    end
  end

  assign tick = (second != second_q);

endmodule

// File: rtl/alarm_scheduler.sv
// Alarm sequencer (IDLE/RING/SNOOZE/DONE) plus hourly chime, arbitrating one speaker; alarm wins.
// SNOOZE_LIMIT_EN caps snoozes per alarm event at MAX_SNOOZE (extra snooze acts as stop).
module alarm_scheduler
  import clock_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  parameter int CHIME_SECONDS  = 3,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarm_on,
  input  logic       sound_on,
  input  logic [5:0] al_hour,
  input  logic [5:0] al_minute,
  input  logic [5:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] second,
  input  logic       stop,
  input  logic       snooze,
  output logic [1:0] spk_sel,
  output logic       ringing,
  output logic       snoozing
);

  localparam int RW = $clog2(RING_SECONDS + 1);
  localparam int SW = $clog2(SNOOZE_MINUTES * 60 + 1);
  localparam int CW = $clog2(CHIME_SECONDS + 1);
  localparam logic [RW-1:0] RING_MAX   = RW'(RING_SECONDS);
  localparam logic [SW-1:0] SNZ_LOAD   = SW'(SNOOZE_MINUTES * 60);
  localparam logic [CW-1:0] CHIME_LOAD = CW'(CHIME_SECONDS);

  logic          tick;
  alarm_state_t  state, state_nx;
  logic [RW-1:0] ring_cnt, ring_cnt_nx;
  logic [SW-1:0] snz_cnt, snz_cnt_nx;
  logic [CW-1:0] chime_cnt, chime_cnt_nx;
  logic [1:0]    spk_nx;
  logic          alarm_match, chime_match, snooze_ok;

  second_tick u_second_tick (
    .clk    (clk),
    .rst    (rst),
    .second (second),
    .tick   (tick)
  );

`ifdef SNOOZE_LIMIT_EN
  localparam int UW = $clog2(MAX_SNOOZE + 1);
  localparam logic [UW-1:0] USED_MAX = UW'(MAX_SNOOZE);
  logic [UW-1:0] snz_used, snz_used_nx;

  assign snooze_ok = (snz_used != USED_MAX);

  always_ff @(posedge clk) begin
    if (rst) snz_used <= '0;
    else     snz_used <= snz_used_nx;
  end
`else
  assign snooze_ok = 1'b1;
`endif

  // Out-of-range alarm settings are excluded explicitly so they can never match.
  assign alarm_match = tick && alarm_on && (al_hour <= MAX_HOUR) && (al_minute <= MAX_MIN) &&
                       (hour == al_hour) && (minute == al_minute) && (second == 6'd0);
  assign chime_match = tick && sound_on && (minute == 6'd0) && (second == 6'd0);

  always_comb begin
    state_nx    = state;
    ring_cnt_nx = ring_cnt;
    snz_cnt_nx  = snz_cnt;
`ifdef SNOOZE_LIMIT_EN
    snz_used_nx = snz_used;
`endif
    case (state)
      IDLE: begin
        if (alarm_match) begin
          state_nx    = RING;
          ring_cnt_nx = '0;
`ifdef SNOOZE_LIMIT_EN
          snz_used_nx = '0;
`endif
        end
      end
      RING: begin
        if (stop || (snooze && !snooze_ok)) begin
          state_nx = DONE;
        end else if (snooze) begin
          state_nx   = SNOOZE;
          snz_cnt_nx = SNZ_LOAD;
`ifdef SNOOZE_LIMIT_EN
          snz_used_nx = snz_used + 1'b1;
`endif
        end else if (tick) begin
          if (ring_cnt != RING_MAX) ring_cnt_nx = ring_cnt + 1'b1;
          if (ring_cnt_nx == RING_MAX) state_nx = DONE;
        end
      end
      SNOOZE: begin
        if (stop) begin
          state_nx = DONE;
        end else if (tick) begin
          if (snz_cnt != '0) snz_cnt_nx = snz_cnt - 1'b1;
          if (snz_cnt_nx == '0) begin
            state_nx    = RING;
            ring_cnt_nx = '0;
          end
        end
      end
      default: begin
        // Waiting out the alarm minute prevents an immediate re-trigger.
        if (tick && (minute != al_minute)) state_nx = IDLE;
      end
    endcase
    if (!alarm_on) begin
      state_nx    = IDLE;
      ring_cnt_nx = '0;
      snz_cnt_nx  = '0;
    end
  end

  always_comb begin
    chime_cnt_nx = chime_cnt;
    if (chime_match)                   chime_cnt_nx = CHIME_LOAD;
    else if (tick && chime_cnt != '0)  chime_cnt_nx = chime_cnt - 1'b1;
    // The alarm owns the speaker: a chime is cut or dropped, never queued.
    if (!sound_on || state_nx == RING) chime_cnt_nx = '0;

    if (state_nx == RING)        spk_nx = SPK_ALARM;
    else if (chime_cnt_nx != '0) spk_nx = SPK_CHIME;
    else                         spk_nx = SPK_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ring_cnt  <= '0;
      snz_cnt   <= '0;
      chime_cnt <= '0;
      spk_sel   <= SPK_OFF;
    end else begin
      state     <= state_nx;
      ring_cnt  <= ring_cnt_nx;
      snz_cnt   <= snz_cnt_nx;
      chime_cnt <= chime_cnt_nx;
      spk_sel   <= spk_nx;
    end
  end

  assign ringing  = (state == RING);
  assign snoozing = (state == SNOOZE);

endmodule

// File: tb/tb_alarm_scheduler.sv
// Bench for alarm_scheduler: directed scenarios plus a randomized run against a reference model.
module tb_alarm_scheduler;

  localparam int RS = 4;
  localparam int SM = 1;
  localparam int CS = 3;
  localparam int MS = 3;
  localparam int M_IDLE = 0, M_RING = 1, M_SNOOZE = 2, M_DONE = 3;
`ifdef SNOOZE_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1, alarm_on = 1'b0, sound_on = 1'b0, stop = 1'b0, snooze = 1'b0;
  logic [5:0] al_hour = '0, al_minute = '0, hour = '0, minute = '0, second = '0;
  logic [1:0] spk_sel;
  logic       ringing, snoozing;

  int total = 0, bad = 0;
  int th = 0, tm = 0, ts = 0;
  int m_st = 0, m_prev = 0, m_ring = 0, m_snz = 0, m_chime = 0, m_used = 0, m_spk = 0;

  always #5 clk = ~clk;

  alarm_scheduler #(
    .RING_SECONDS(RS), .SNOOZE_MINUTES(SM), .CHIME_SECONDS(CS), .MAX_SNOOZE(MS)
  ) dut (
    .clk(clk), .rst(rst), .alarm_on(alarm_on), .sound_on(sound_on),
    .al_hour(al_hour), .al_minute(al_minute), .hour(hour), .minute(minute), .second(second),
    .stop(stop), .snooze(snooze), .spk_sel(spk_sel), .ringing(ringing), .snoozing(snoozing)
  );

  // Reference model: one call per clock edge, using the inputs present at that edge.
  task automatic model_edge();
    bit tk;
    int nst;
    if (rst) begin
      m_st = M_IDLE; m_ring = 0; m_snz = 0; m_chime = 0; m_used = 0; m_spk = 0;
      m_prev = int'(second);
      return;
    end
    tk = (int'(second) != m_prev);
    m_prev = int'(second);
    nst = m_st;
    if (!alarm_on) begin
      nst = M_IDLE; m_ring = 0; m_snz = 0;
    end else begin
      case (m_st)
        M_IDLE: if (tk && hour == al_hour && minute == al_minute && second == 0) begin
          nst = M_RING; m_ring = 0; m_used = 0;
        end
        M_RING: begin
          if (stop) nst = M_DONE;
          else if (snooze) begin
            if (LIMIT && m_used == MS) nst = M_DONE;
            else begin nst = M_SNOOZE; m_snz = SM * 60; m_used++; end
          end else if (tk) begin
            m_ring++;
            if (m_ring >= RS) nst = M_DONE;
          end
        end
        M_SNOOZE: begin
          if (stop) nst = M_DONE;
          else if (tk) begin
            m_snz--;
            if (m_snz == 0) begin nst = M_RING; m_ring = 0; end
          end
        end
        default: if (tk && minute != al_minute) nst = M_IDLE;
      endcase
    end
    if (tk) begin
      if (sound_on && minute == 0 && second == 0) m_chime = CS;
      else if (m_chime > 0) m_chime--;
    end
    if (!sound_on || nst == M_RING) m_chime = 0;
    m_st  = nst;
    m_spk = (nst == M_RING) ? 2 : ((m_chime > 0) ? 1 : 0);
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      stop = 1'b0;
      snooze = 1'b0;
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    th = h; tm = m; ts = s;
    hour = 6'(h); minute = 6'(m); second = 6'(s);
  endtask

  task automatic bump_sec();
    ts++;
    if (ts == 60) begin
      ts = 0; tm++;
      if (tm == 60) begin tm = 0; th = (th + 1) % 24; end
    end
    set_time(th, tm, ts);
  endtask

  task automatic tick_sec(input int n);
    bump_sec();
    advance(n);
  endtask

  task automatic arm_and_ring(input int h, input int m);
    alarm_on = 1'b0;
    advance(1);
    alarm_on = 1'b1;
    al_hour = 6'(h); al_minute = 6'(m);
    set_time(h, m - 1, 59);
    advance(2);
    set_time(h, m, 0);
    advance(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; alarm_on = 1'b1; sound_on = 1'b1;
    al_hour = 6'd12; al_minute = 6'd0;
    set_time(12, 0, 0);
    advance(3);
    rst = 1'b0;
    advance(1);
    total++; if (spk_sel !== 2'b00) begin bad++; $display("FAIL reset_spk got=%b want=00", spk_sel); end
    total++; if (ringing !== 1'b0) begin bad++; $display("FAIL reset_ringing got=%b want=0", ringing); end
    total++; if (snoozing !== 1'b0) begin bad++; $display("FAIL reset_snoozing got=%b want=0", snoozing); end
    advance(3);
    total++; if (spk_sel !== 2'b00) begin bad++; $display("FAIL reset_quiet got=%b want=00", spk_sel); end
  endtask

  task automatic test_ring();
    alarm_on = 1'b1; sound_on = 1'b0;
    al_hour = 6'd7; al_minute = 6'd30;
    set_time(7, 29, 58); advance(2);
    set_time(7, 29, 59); advance(2);
    total++; if (ringing !== 1'b0) begin bad++; $display("FAIL ring_early got=%b want=0", ringing); end
    set_time(7, 30, 0); advance(1);
    total++; if (ringing !== 1'b1) begin bad++; $display("FAIL ring_start got=%b want=1", ringing); end
    total++; if (spk_sel !== 2'b10) begin bad++; $display("FAIL ring_spk got=%b want=10", spk_sel); end
    for (int k = 1; k <= 4; k++) begin
      tick_sec(2);
      total++;
      if (ringing !== (k < 4)) begin bad++; $display("FAIL ring_len tick=%0d got=%b want=%b", k, ringing, k < 4); end
      total++;
      if (spk_sel !== ((k < 4) ? 2'b10 : 2'b00)) begin
        bad++; $display("FAIL ring_len_spk tick=%0d got=%b", k, spk_sel);
      end
    end
  endtask

  task automatic test_snooze();
    arm_and_ring(7, 30);
    total++; if (ringing !== 1'b1) begin bad++; $display("FAIL snz_ring got=%b want=1", ringing); end
    snooze = 1'b1; advance(1);
    total++; if (snoozing !== 1'b1) begin bad++; $display("FAIL snz_enter got=%b want=1", snoozing); end
    total++; if (spk_sel !== 2'b00) begin bad++; $display("FAIL snz_spk got=%b want=00", spk_sel); end
    for (int i = 1; i <= 60; i++) begin
      tick_sec(2);
      if (i == 59) begin
        total++; if (snoozing !== 1'b1) begin bad++; $display("FAIL snz_hold got=%b want=1", snoozing); end
      end
    end
    total++; if (ringing !== 1'b1) begin bad++; $display("FAIL snz_reRing got=%b want=1", ringing); end
    total++; if (spk_sel !== 2'b10) begin bad++; $display("FAIL snz_reRing_spk got=%b want=10", spk_sel); end
  endtask

  task automatic test_stop_wins();
    arm_and_ring(7, 30);
    tick_sec(2);
    stop = 1'b1; snooze = 1'b1; advance(1);
    total++; if ({ringing, snoozing} !== 2'b00) begin bad++; $display("FAIL stop_wins got=%b want=00", {ringing, snoozing}); end
    set_time(7, 30, 0); advance(2);
    total++; if (ringing !== 1'b0) begin bad++; $display("FAIL no_retrigger got=%b want=0", ringing); end
    set_time(7, 30, 59); advance(2);
    set_time(7, 31, 0); advance(2);
    set_time(7, 30, 59); advance(2);
    set_time(7, 30, 0); advance(1);
    total++; if (ringing !== 1'b1) begin bad++; $display("FAIL idle_after_minute got=%b want=1", ringing); end
  endtask

  task automatic test_chime();
    alarm_on = 1'b0; sound_on = 1'b1; advance(1);
    set_time(7, 59, 59); advance(2);
    set_time(8, 0, 0); advance(1);
    total++; if (spk_sel !== 2'b01) begin bad++; $display("FAIL chime_start got=%b want=01", spk_sel); end
    for (int k = 1; k <= 3; k++) begin
      tick_sec(2);
      total++;
      if (spk_sel !== ((k < 3) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL chime_len tick=%0d got=%b", k, spk_sel); end
    end
    alarm_on = 1'b1; al_hour = 6'd8; al_minute = 6'd0;
    set_time(7, 59, 59); advance(2);
    set_time(8, 0, 0); advance(1);
    total++; if (spk_sel !== 2'b10) begin bad++; $display("FAIL chime_vs_alarm got=%b want=10", spk_sel); end
    tick_sec(2);
    total++; if (spk_sel !== 2'b10) begin bad++; $display("FAIL chime_vs_alarm2 got=%b want=10", spk_sel); end
    for (int k = 0; k < 3; k++) tick_sec(2);
    total++; if (spk_sel !== 2'b00) begin bad++; $display("FAIL chime_not_resumed got=%b want=00", spk_sel); end
    sound_on = 1'b0;
  endtask

  task automatic test_abort();
    arm_and_ring(7, 30);
    alarm_on = 1'b0; advance(1);
    total++; if ({ringing, spk_sel} !== 3'b000) begin bad++; $display("FAIL alarm_off got=%b want=000", {ringing, spk_sel}); end
    arm_and_ring(7, 30);
    snooze = 1'b1; advance(1);
    rst = 1'b1; advance(1); rst = 1'b0;
    total++; if ({ringing, snoozing, spk_sel} !== 4'b0000) begin bad++; $display("FAIL rst_mid got=%b want=0000", {ringing, snoozing, spk_sel}); end
    for (int i = 0; i < 62; i++) tick_sec(1);
    total++; if ({ringing, snoozing} !== 2'b00) begin bad++; $display("FAIL snooze_lost got=%b want=00", {ringing, snoozing}); end
  endtask

  task automatic test_snooze_limit();
    arm_and_ring(7, 30);
    for (int s = 1; s <= 3; s++) begin
      snooze = 1'b1; advance(1);
      total++; if (snoozing !== 1'b1) begin bad++; $display("FAIL lim_snooze n=%0d got=%b want=1", s, snoozing); end
      for (int i = 0; i < 60; i++) tick_sec(1);
      total++; if (ringing !== 1'b1) begin bad++; $display("FAIL lim_ring n=%0d got=%b want=1", s, ringing); end
    end
    snooze = 1'b1; advance(1);
    total++;
    if (snoozing !== !LIMIT || ringing !== 1'b0) begin
      bad++; $display("FAIL lim_fourth got r=%b s=%b want r=0 s=%b", ringing, snoozing, !LIMIT);
    end
  endtask

  task automatic test_random();
    alarm_on = 1'b1; sound_on = 1'b1;
    al_hour = 6'd8; al_minute = 6'd0;
    set_time(7, 59, 50); advance(2);
    for (int c = 0; c < 4000; c++) begin
      int r;
      rst = 1'b0;
      r = int'($urandom_range(0, 999));
      if (r < 300)      bump_sec();
      else if (r < 320) stop = 1'b1;
      else if (r < 360) snooze = 1'b1;
      else if (r < 365) alarm_on = ~alarm_on;
      else if (r < 368) sound_on = ~sound_on;
      else if (r < 370) rst = 1'b1;
      else if (r < 376) set_time(7, 59, 57);
      else if (r < 378) al_minute = (al_minute == 6'd0) ? 6'd1 : 6'd0;
      advance(1);
      total++;
      if (ringing !== (m_st == M_RING) || snoozing !== (m_st == M_SNOOZE)) begin
        bad++; $display("FAIL rnd_state cyc=%0d got r=%b s=%b want st=%0d", c, ringing, snoozing, m_st);
      end
      total++;
      if (spk_sel !== 2'(m_spk)) begin bad++; $display("FAIL rnd_spk cyc=%0d got=%b want=%0d", c, spk_sel, m_spk); end
    end
  endtask

  initial begin
    test_reset();
    test_ring();
    test_snooze();
    test_stop_wins();
    test_chime();
    test_abort();
    test_snooze_limit();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
